filter_avmm_responder: RTL and testbench
========================================

// Module: filter_avmm_responder
// PURPOSE
//  Avalon-MM slave (responder) inside the cycloneV_soc Qsys system, on the HPS lightweight bridge.
//  HPS software writes signed samples into an input FIFO.
//  The block runs a 4-tap moving-sum filter, then shifts and saturates each sum to DATA_W.
//  Software reads one result per read; a sticky overflow flag records every saturation event.
// PARAMETERS
//  DATA_W      16  sample/result width, signed two's complement (2..30)
//  FIFO_DEPTH  8   input FIFO entries, power of two (2..128)
//  ADDR_W      3   word address width
// PORTS
//  clk_clk        in   1       system clock
//  reset_reset_n  in   1       reset
//  address        in   ADDR_W  word address
//  read           in   1       read strobe, one cycle per access
//  write          in   1       write strobe, one cycle per access
//  writedata      in   32      write data
//  readdata       out  32      read data, fixed read latency 1
//  irq            out  1       level-high interrupt: out_valid & CTRL.irq_en
// BEHAVIOUR
//  Clock and reset: one clock (clk_clk); reset_reset_n asynchronous, active-low.
//  Reset state: readdata=0, irq=0, CTRL=0, SHIFT=0, FIFO empty, taps=0, pipeline invalid,
//   out_valid=0, result=0, overflow=0, drop=0.
//  Register map (word addresses):
//   0 CTRL   RW  [0] enable; [1] irq_en; [2] clr_flags (self-clearing, clears overflow+drop);
//                [3] flush (self-clearing). Bits 2 and 3 read back 0.
//   1 STATUS RO  [0] fifo_empty; [1] fifo_full; [2] out_valid; [3] overflow; [4] drop;
//                [15:8] fifo level.
//   2 SAMPLE WO  writedata[DATA_W-1:0] pushed to FIFO; reads return 0.
//   3 RESULT RO  sign-extended result; a read with out_valid=1 pops it (out_valid->0).
//                A read with out_valid=0 returns the held value and changes nothing.
//   4 SHIFT  RW  [4:0] arithmetic right-shift amount; values > DATA_W+1 clamp to DATA_W+1.
//   5-7          reads return 0, writes ignored.
//  Avalon: no waitrequest; readdata registered one cycle after read. Reads have no side
//   effects other than the RESULT pop.
//  Pipeline, 3 stages, global stall:
//   S1 pop FIFO head into tap line.  S2 sum of 4 taps, width DATA_W+2, never wraps.
//   S3 sum >>> SHIFT, saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] into the result register.
//   Saturation at S3 sets overflow (sticky).
//   Advance condition: slot free = (!out_valid | RESULT read this cycle).
//   Pop condition: enable & !empty & advance.
//   Latency: sample written at edge T into an idle, empty pipeline -> out_valid=1 after edge T+3.
//   Taps start at 0, so the first 3 results are partial sums.
//  enable=0: no pops; samples in flight still drain to the result register.
//  FIFO full and SAMPLE write: accepted if a pop occurs the same cycle; otherwise dropped,
//   drop set.
//  SAMPLE write and clr_flags in the same cycle: a drop from that write wins (drop=1).
//  Saturation and clr_flags in the same cycle: the new overflow wins.
//  flush: empties FIFO, zeroes taps, invalidates pipeline, clears out_valid. Sticky flags and
//   registers are kept. A SAMPLE write in the same cycle is discarded without setting drop.
//  Reset asserted mid-operation: every register returns to its reset state immediately.
// STRUCTURE
//  filter_avmm_pkg: register addresses, CTRL/STATUS bit indices, SHIFT clamp constant.
//  Sub-module sync_fifo (DATA_W x FIFO_DEPTH): push, pop, flush, empty, full, level.
//   Same-cycle push and pop are legal when full.
//  Top level holds the register file, tap line, S2/S3 pipeline and the read mux.
// TESTING (DATA_W=16, FIFO_DEPTH=8)
//  1 Reset: read STATUS -> 0x00000001; read RESULT -> 0; irq=0.
//  2 SHIFT=2, CTRL=1, write 100,200,300,400, reading each result:
//    results 25,75,150,250; first out_valid 3 edges after the first write.
//  3 SHIFT=0, write 0x7FFF x2 -> results 32767, 32767 with overflow=1 after the 2nd.
//    Write CTRL=0x5 -> overflow=0.
//    Write -32768 x2 -> -32768 and saturated -32768, overflow=1.
//  4 CTRL=0, write 9 samples -> STATUS full=1, level=8, drop=1.
//    Set enable; the pop frees one slot. A same-cycle write is accepted, level stays 8.
//  5 Backpressure: enable, write 1,2,3 with SHIFT=0 and no reads -> out_valid=1, pipeline stalled.
//    Three reads return 1,3,6; irq follows out_valid when irq_en=1.
//  6 Mid-stream flush, then reset: after flush STATUS=0x0001 | sticky bits, taps 0
//    (next single sample 5 -> result 5).
//    reset_reset_n low mid-pipeline -> all state back to reset values.

Source files
------------

// File: rtl/filter_avmm_pkg.sv
// Shared constants for the filter Avalon-MM responder: register map, bit indices and
// the shift clamp helper.
package filter_avmm_pkg;

    localparam int unsigned ADDR_CTRL   = 0;
    localparam int unsigned ADDR_STATUS = 1;
    localparam int unsigned ADDR_SAMPLE = 2;
    localparam int unsigned ADDR_RESULT = 3;
    localparam int unsigned ADDR_SHIFT  = 4;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLR    = 2;
    localparam int unsigned CTRL_FLUSH  = 3;

    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OUT_VALID = 2;
    localparam int unsigned STAT_OVERFLOW  = 3;
    localparam int unsigned STAT_DROP      = 4;
    localparam int unsigned STAT_LEVEL_LSB = 8;

    // Shifting a DATA_W+2 sum by more than DATA_W+1 cannot change the result further.
    function automatic logic [4:0] shift_clamp(input logic [4:0] amt, input int unsigned data_w);
        if (32'(amt) > data_w + 32'd1) begin
            return 5'(data_w + 32'd1);
        end
        return amt;
    endfunction

endpackage

// File: rtl/filter_avmm_responder_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop happens
// in the same cycle.
module sync_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/filter_avmm_responder.sv
// Avalon-MM responder: sample FIFO, 4-tap moving sum, shift and saturate, one result per read.
// Whole pipeline stalls while an unread result is held.
module filter_avmm_responder
    import filter_avmm_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);
    localparam int unsigned SUM_W = DATA_W + 2;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = $signed({3'b000, {(DATA_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN = $signed({3'b111, {(DATA_W-1){1'b0}}});

    logic                    enable, irq_en, overflow, drop;
    logic [4:0]              shift_amt;
    logic [3:0][DATA_W-1:0]  taps;
    logic                    s1_valid, s2_valid, out_valid;
    logic signed [SUM_W-1:0] s2_sum;
    logic [DATA_W-1:0]       result;

    logic                    wr_ctrl, wr_sample, wr_shift, rd_result;
    logic                    clr_flags, flush, advance, pop, push, drop_evt, s3_fire;
    logic                    fifo_empty, fifo_full;
    logic [LVL_W-1:0]        fifo_level;
    logic [DATA_W-1:0]       fifo_rdata;
    logic signed [SUM_W-1:0] tap_sum, shifted;
    logic [DATA_W-1:0]       sat_val;
    logic                    sat_hit;
    logic [31:0]             rd_mux;
    logic                    unused_wd;

    assign unused_wd = ^writedata[31:DATA_W];

    assign wr_ctrl   = write && (address == ADDR_W'(ADDR_CTRL));
    assign wr_sample = write && (address == ADDR_W'(ADDR_SAMPLE));
    assign wr_shift  = write && (address == ADDR_W'(ADDR_SHIFT));
    assign rd_result = read && (address == ADDR_W'(ADDR_RESULT)) && out_valid;
    assign clr_flags = wr_ctrl & writedata[CTRL_CLR];
    assign flush     = wr_ctrl & writedata[CTRL_FLUSH];

    assign advance  = ~out_valid | rd_result;
    assign pop      = enable & ~fifo_empty & advance & ~flush;
    assign push     = wr_sample & ~flush;
    assign drop_evt = push & fifo_full & ~pop;
    assign s3_fire  = advance & s2_valid & ~flush;
    assign irq      = out_valid & irq_en;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (writedata[DATA_W-1:0]),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    always_comb begin
        tap_sum = '0;
        for (int i = 0; i < 4; i++) begin
            tap_sum = tap_sum + $signed({{2{taps[i][DATA_W-1]}}, taps[i]});
        end
    end

    always_comb begin
        shifted = s2_sum >>> shift_amt;
        sat_hit = 1'b0;
        sat_val = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
            sat_hit = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
            sat_hit = 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_W'(ADDR_CTRL):   rd_mux = {30'b0, irq_en, enable};
            ADDR_W'(ADDR_STATUS): begin
                rd_mux[STAT_EMPTY]     = fifo_empty;
                rd_mux[STAT_FULL]      = fifo_full;
                rd_mux[STAT_OUT_VALID] = out_valid;
                rd_mux[STAT_OVERFLOW]  = overflow;
                rd_mux[STAT_DROP]      = drop;
                rd_mux[STAT_LEVEL_LSB +: 8] = 8'(fifo_level);
            end
            ADDR_W'(ADDR_RESULT): rd_mux = {{(32-DATA_W){result[DATA_W-1]}}, result};
            ADDR_W'(ADDR_SHIFT):  rd_mux = {27'b0, shift_amt};
            default:              rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            shift_amt <= '0;
            overflow  <= 1'b0;
            drop      <= 1'b0;
            taps      <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_sum    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            readdata  <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= writedata[CTRL_ENABLE];
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (wr_shift) shift_amt <= shift_clamp(writedata[4:0], DATA_W);
            // Later assignments win: a new event beats a same-cycle clear.
            if (clr_flags) overflow <= 1'b0;
            if (s3_fire && sat_hit) overflow <= 1'b1;
            if (clr_flags) drop <= 1'b0;
            if (drop_evt) drop <= 1'b1;
            if (flush) begin
                taps      <= '0;
                s1_valid  <= 1'b0;
                s2_valid  <= 1'b0;
                out_valid <= 1'b0;
            end else if (advance) begin
                if (pop) taps <= {taps[2:0], fifo_rdata};
                s1_valid  <= pop;
                s2_valid  <= s1_valid;
                s2_sum    <= tap_sum;
                out_valid <= s2_valid;
                if (s2_valid) result <= sat_val;
            end
            if (read) readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_filter_avmm_responder.sv
// Directed bench for filter_avmm_responder: reads queue their expected data, and a monitor
// compares readdata one cycle after each read.
module tb_filter_avmm_responder;

    localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_SAMPLE = 3'd2;
    localparam logic [2:0] A_RESULT = 3'd3, A_SHIFT = 3'd4, A_SPARE = 3'd5;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    filter_avmm_responder #(
        .DATA_W     (16),
        .FIFO_DEPTH (8),
        .ADDR_W     (3)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .irq           (irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        exp_q.push_back('{name: name, exp: exp});
        address = a;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
    endtask

    // Monitor: a read seen at one falling edge has its data registered by the next one.
    initial begin
        bit   pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk_clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", readdata, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, readdata, e.exp);
                end
            end
            pend = read;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s2_in  [4] = '{32'd100, 32'd200, 32'd300, 32'd400};
        logic [31:0] s2_exp [4] = '{32'd25, 32'd75, 32'd150, 32'd250};

        // 1: reset state
        tick(3);
        reset_reset_n = 1'b1;
        tick(1);
        check("reset_irq", {31'b0, irq}, 32'd0);
        bus_read(A_STATUS, 32'h0000_0001, "reset_status");
        bus_read(A_RESULT, 32'h0, "reset_result");
        bus_read(A_CTRL, 32'h0, "reset_ctrl");

        // 2: moving sum with shift 2, latency via irq
        bus_write(A_SHIFT, 32'd2);
        bus_write(A_CTRL, 32'h3);
        bus_write(A_SAMPLE, s2_in[0]);
        tick(2);
        check("latency_edge2_irq", {31'b0, irq}, 32'd0);
        tick(1);
        check("latency_edge3_irq", {31'b0, irq}, 32'd1);
        bus_read(A_RESULT, s2_exp[0], "sum_r0");
        for (int i = 1; i < 4; i++) begin
            bus_write(A_SAMPLE, s2_in[i]);
            tick(4);
            bus_read(A_RESULT, s2_exp[i], $sformatf("sum_r%0d", i));
        end
        check("irq_after_pop", {31'b0, irq}, 32'd0);
        bus_read(A_CTRL, 32'h3, "ctrl_readback");
        bus_read(A_SHIFT, 32'd2, "shift_readback");
        bus_write(A_SHIFT, 32'd31);
        bus_read(A_SHIFT, 32'd17, "shift_clamp");
        bus_write(A_SHIFT, 32'd0);
        bus_read(A_SAMPLE, 32'h0, "sample_reads_zero");
        bus_read(A_SPARE, 32'h0, "spare_reads_zero");

        // 3: positive and negative saturation, sticky overflow and clear
        bus_write(A_CTRL, 32'h9);
        bus_write(A_SAMPLE, 32'h0000_7FFF);
        tick(4);
        bus_read(A_RESULT, 32'h0000_7FFF, "pos_first");
        bus_write(A_SAMPLE, 32'h0000_7FFF);
        tick(4);
        bus_read(A_RESULT, 32'h0000_7FFF, "pos_saturated");
        bus_read(A_STATUS, 32'h0000_0009, "pos_overflow_status");
        bus_write(A_CTRL, 32'h5);
        bus_read(A_STATUS, 32'h0000_0001, "overflow_cleared");
        bus_write(A_CTRL, 32'h9);
        bus_write(A_SAMPLE, 32'hFFFF_8000);
        tick(4);
        bus_read(A_RESULT, 32'hFFFF_8000, "neg_first");
        bus_write(A_SAMPLE, 32'hFFFF_8000);
        tick(4);
        bus_read(A_RESULT, 32'hFFFF_8000, "neg_saturated");
        bus_read(A_STATUS, 32'h0000_0009, "neg_overflow_status");

        // 4: full FIFO, drop, and push accepted alongside a pop
        bus_write(A_CTRL, 32'hC);
        for (int i = 1; i <= 9; i++) bus_write(A_SAMPLE, 32'(i));
        bus_read(A_STATUS, 32'h0000_0812, "full_drop_status");
        bus_write(A_CTRL, 32'h4);
        bus_read(A_STATUS, 32'h0000_0802, "drop_cleared_status");
        bus_write(A_CTRL, 32'h1);
        bus_write(A_SAMPLE, 32'd10);
        bus_read(A_STATUS, 32'h0000_0802, "push_with_pop_status");

        // 5: backpressure, stalled pipeline drains one result per read
        bus_write(A_CTRL, 32'hB);
        bus_write(A_SAMPLE, 32'd1);
        bus_write(A_SAMPLE, 32'd2);
        bus_write(A_SAMPLE, 32'd3);
        tick(6);
        check("stall_irq_high", {31'b0, irq}, 32'd1);
        bus_read(A_STATUS, 32'h0000_0005, "stall_status");
        bus_read(A_RESULT, 32'd1, "stall_r0");
        bus_read(A_RESULT, 32'd3, "stall_r1");
        bus_read(A_RESULT, 32'd6, "stall_r2");
        check("drained_irq_low", {31'b0, irq}, 32'd0);
        bus_read(A_RESULT, 32'd6, "held_result");
        bus_read(A_STATUS, 32'h0000_0001, "drained_status");

        // 6: flush mid-stream, then reset mid-pipeline
        bus_write(A_SAMPLE, 32'd7);
        tick(1);
        bus_write(A_CTRL, 32'hB);
        tick(4);
        check("flush_irq_low", {31'b0, irq}, 32'd0);
        bus_read(A_STATUS, 32'h0000_0001, "flush_status");
        bus_write(A_SAMPLE, 32'd5);
        tick(4);
        bus_read(A_RESULT, 32'd5, "after_flush_result");
        bus_write(A_SHIFT, 32'd3);
        bus_write(A_SAMPLE, 32'd9);
        tick(1);
        reset_reset_n = 1'b0;
        #2;
        check("async_reset_readdata", readdata, 32'h0);
        tick(2);
        reset_reset_n = 1'b1;
        tick(3);
        check("post_reset_irq", {31'b0, irq}, 32'd0);
        bus_read(A_STATUS, 32'h0000_0001, "post_reset_status");
        bus_read(A_RESULT, 32'h0, "post_reset_result");
        bus_read(A_CTRL, 32'h0, "post_reset_ctrl");
        bus_read(A_SHIFT, 32'h0, "post_reset_shift");

        tick(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
